// File: rtl/wb_defs_pkg.sv
// wb_defs -- definitions shared between the Wishbone test master and its slaves.
//
// Contents:
//   slave_state_t  : 2-bit slave FSM encoding (IDLE, WAIT, RESP, HOLD)
//   WB_TERM_*      : cycle termination codes, packed as {err, ack}
//   WAIT_CNT_WIDTH : width of the slave wait-state counter (0..15 wait states)
//   term_for()     : maps an address-decode result to its termination code
package wb_defs;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_RESP = 2'd2,
    SLV_HOLD = 2'd3
  } slave_state_t;

  localparam logic [1:0] WB_TERM_NONE = 2'b00;
  localparam logic [1:0] WB_TERM_ACK  = 2'b01;
  localparam logic [1:0] WB_TERM_ERR  = 2'b10;

  localparam int WAIT_CNT_WIDTH = 4;

  // A decoded address ends its cycle with ack; anything else ends it with err.
  function automatic logic [1:0] term_for(input logic addr_valid);
    return addr_valid ? WB_TERM_ACK : WB_TERM_ERR;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode -- combinational Wishbone slave address decoder.
//
// Turns a bus address into a word index for a slave whose window starts at
// BASE_ADDRESS and holds DATA_COUNT words spaced AU_IN_DATA units apart.
//
// Ports:
//   adr    in   ADDR_WIDTH   bus address
//   valid  out  1            address falls on a word inside the window
//   index  out  INDEX_WIDTH  word index (only meaningful when valid)
module wb_addr_decode #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BASE_ADDRESS = 0,
  parameter int AU_IN_DATA   = 1,
  parameter int DATA_COUNT   = 16,
  parameter int INDEX_WIDTH  = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1
) (
  input  logic [ADDR_WIDTH-1:0]  adr,
  output logic                   valid,
  output logic [INDEX_WIDTH-1:0] index
);

  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(AU_IN_DATA);
  // One extra bit so a full 2^ADDR_WIDTH word window can be expressed.
  localparam logic [ADDR_WIDTH:0]   COUNT  = (ADDR_WIDTH + 1)'(DATA_COUNT);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // Addresses below the base would wrap the subtraction, so they are
  // rejected explicitly rather than relying on the range check.
  assign offset = adr - BASE;
  assign word   = offset / STRIDE;
  assign valid  = (adr >= BASE) && ((offset % STRIDE) == '0) && ({1'b0, word} < COUNT);
  assign index  = word[INDEX_WIDTH-1:0];

endmodule

// File: rtl/wb_slave_mem.sv
// wb_slave_mem -- Wishbone classic-cycle slave backed by a register array.
//
// Each accepted strobe produces exactly one single-cycle termination (ack for
// a decoded address, err otherwise) after WAIT_STATES extra cycles, then the
// slave waits for the strobe to fall before accepting another request.
//
// Ports:
//   clk    in   1           clock, rising edge
//   rst    in   1           asynchronous reset, active-low
//   cyc_i  in   1           master cycle valid
//   stb_i  in   1           master strobe
//   we_i   in   1           1 = write, 0 = read
//   adr_i  in   ADDR_WIDTH  address
//   dat_i  in   DATA_WIDTH  write data
//   dat_o  out  DATA_WIDTH  registered read data
//   ack_o  out  1           normal termination pulse
//   err_o  out  1           error termination pulse
module wb_slave_mem
  import wb_defs::*;
#(
  parameter int BASE_ADDRESS = 0,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_COUNT   = 16,
  parameter int AU_IN_DATA   = 1,
  parameter int WAIT_STATES  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int INDEX_WIDTH = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
  // The counter runs WAIT_STATES-1 .. 0, so the last WAIT cycle is the one
  // that sees zero and moves to RESP.
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_WIDTH'(WAIT_STATES - 1) : '0;

  slave_state_t state, next_state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic [1:0] term;
  logic [DATA_WIDTH-1:0] mem [DATA_COUNT];

  logic req;
  logic commit;
  logic adr_valid;
  logic [INDEX_WIDTH-1:0] adr_index;

  assign req = cyc_i & stb_i;

  wb_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BASE_ADDRESS(BASE_ADDRESS),
    .AU_IN_DATA  (AU_IN_DATA),
    .DATA_COUNT  (DATA_COUNT),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_decode (
    .adr  (adr_i),
    .valid(adr_valid),
    .index(adr_index)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SLV_IDLE;
    else      state <= next_state;
  end

  // A request that drops while waiting abandons the cycle; in HOLD the slave
  // refuses to respond again until the master releases the strobe.
  always_comb begin
    next_state = state;
    case (state)
      SLV_IDLE: if (req) next_state = (WAIT_STATES == 0) ? SLV_RESP : SLV_WAIT;
      SLV_WAIT: begin
        if (!req)                next_state = SLV_IDLE;
        else if (wait_cnt == '0) next_state = SLV_RESP;
      end
      SLV_RESP: next_state = SLV_HOLD;
      SLV_HOLD: if (!req) next_state = SLV_IDLE;
      default:  next_state = SLV_IDLE;
    endcase
  end

  // The access happens once, on the edge that enters RESP.
  assign commit = (next_state == SLV_RESP) && (state != SLV_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == SLV_IDLE && req) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == SLV_WAIT && req && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Memory, read register and termination code all update together at
  // commit; an error clears dat_o so stale data is never presented with err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DATA_COUNT; i++) mem[i] <= '0;
      dat_o <= '0;
      term  <= WB_TERM_NONE;
    end else if (commit) begin
      term <= term_for(adr_valid);
      if (adr_valid) begin
        if (we_i) mem[adr_index] <= dat_i;
        else      dat_o          <= mem[adr_index];
      end else begin
        dat_o <= '0;
      end
    end
  end

  always_comb begin
    ack_o = (state == SLV_RESP) && (term == WB_TERM_ACK);
    err_o = (state == SLV_RESP) && (term == WB_TERM_ERR);
  end

endmodule
